drp_wb: RTL and testbench

DRP responder that bridges a Xilinx-style DRP port to a Wishbone classic master. It lets a DRP initiator such as wb_drp, a transceiver-attached DRP controller or a DRP-driven debug agent access Wishbone register blocks. It is the opposite end of the DRP link from wb_drp:
- one DRP transaction in, one Wishbone cycle out, one drp_rdy pulse back.
- sits between any DRP initiator and Wishbone register space in the XFCP/transceiver-management fabric.

---
 rtl/drp_wb_pkg.sv | 12 +
 rtl/drp_wb.sv | 136 +++++++++++++
 tb/tb_drp_wb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/drp_wb_pkg.sv
// drp_wb_pkg: shared types and constants for the DRP-to-Wishbone responder.
package drp_wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [1:0]  WB_SEL_ALL       = 2'b11;
    localparam logic [15:0] DEFAULT_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/drp_wb.sv
// drp_wb: DRP responder driving a Wishbone classic master cycle.
// One DRP transaction in, one Wishbone cycle out, one drp_rdy pulse back.
// Optional bus timeout enabled by defining DRP_WB_TIMEOUT_EN.
module drp_wb
    import drp_wb_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH     = 10,
    parameter logic [15:0]     ERR_DATA       = DEFAULT_ERR_DATA,
    parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] drp_addr,
    input  logic [15:0]           drp_di,
    output logic [15:0]           drp_do,
    input  logic                  drp_en,
    input  logic                  drp_we,
    output logic                  drp_rdy,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    input  logic [15:0]           wb_dat_i,
    output logic [15:0]           wb_dat_o,
    output logic                  wb_we_o,
    output logic [1:0]            wb_sel_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  wb_cyc_o,
    output logic                  overrun,
    output logic                  timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("drp_wb: TIMEOUT_CYCLES must be >= 2");
    end

    state_t state, state_next;
    logic   accept;
    logic   complete;
    logic   expire;

`ifdef DRP_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a response or a timeout ends the bus phase.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (drp_en)              state_next = BUS;
            BUS:     if (complete || expire)  state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Control decode; a response in the expiry cycle takes priority over the timeout.
    always_comb begin
        accept   = (state == IDLE) && drp_en;
        complete = (state == BUS) && (wb_ack_i || wb_err_i);
`ifdef DRP_WB_TIMEOUT_EN
        expire   = (state == BUS) && !complete && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        expire   = 1'b0;
`endif
    end

    // Wishbone request, DRP response and status pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            drp_do   <= '0;
            drp_rdy  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            drp_rdy <= 1'b0;
            overrun <= (state == BUS) && drp_en;
            if (accept) begin
                wb_adr_o <= drp_addr;
                wb_dat_o <= drp_di;
                wb_we_o  <= drp_we;
                wb_sel_o <= WB_SEL_ALL;
                wb_stb_o <= 1'b1;
                wb_cyc_o <= 1'b1;
            end
            if (complete || expire) begin
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
                wb_stb_o <= 1'b0;
                wb_cyc_o <= 1'b0;
                drp_rdy  <= 1'b1;
                if (!wb_we_o) begin
                    drp_do <= (wb_err_i || expire) ? ERR_DATA : wb_dat_i;
                end
            end
        end
    end

`ifdef DRP_WB_TIMEOUT_EN
    // Bus-phase cycle counter, cleared on entry to BUS.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == BUS) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Timeout pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_drp_wb.sv
// tb_drp_wb: directed self-checking bench for drp_wb.
module tb_drp_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  drp_addr = '0;
    logic [15:0] drp_di = '0;
    logic [15:0] drp_do;
    logic        drp_en = 1'b0;
    logic        drp_we = 1'b0;
    logic        drp_rdy;
    logic [9:0]  wb_adr_o;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_we_o;
    logic [1:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_cyc_o;
    logic        overrun;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    drp_wb #(
        .ADDR_WIDTH(10),
        .ERR_DATA(16'hFFFF),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_cyc_o(wb_cyc_o),
        .overrun(overrun), .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic we, input logic [9:0] addr, input logic [15:0] di);
        drp_en = 1'b1; drp_we = we; drp_addr = addr; drp_di = di;
        tick();
        drp_en = 1'b0; drp_we = 1'b0; drp_addr = '0; drp_di = '0;
    endtask

    initial begin
        int hits;

        // reset
        tick(); tick();
        rst = 1'b0;
        check("rst_do", drp_do, 0);
        check("rst_rdy", drp_rdy, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_ovr", overrun, 0);
        check("rst_to", timeout, 0);

        // write, ack in third bus cycle
        start(1'b1, 10'h045, 16'hBEEF);
        check("wr_stb", wb_stb_o, 1);
        check("wr_cyc", wb_cyc_o, 1);
        check("wr_adr", wb_adr_o, 10'h045);
        check("wr_dat", wb_dat_o, 16'hBEEF);
        check("wr_we", wb_we_o, 1);
        check("wr_sel", wb_sel_o, 2'b11);
        tick(); tick();
        check("wr_wait_rdy", drp_rdy, 0);
        check("wr_wait_stb", wb_stb_o, 1);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("wr_rdy", drp_rdy, 1);
        check("wr_cyc_drop", wb_cyc_o, 0);
        check("wr_stb_drop", wb_stb_o, 0);
        check("wr_we_drop", wb_we_o, 0);
        check("wr_sel_drop", wb_sel_o, 0);
        check("wr_do_keep", drp_do, 0);
        tick();
        check("wr_rdy_pulse", drp_rdy, 0);

        // read with immediate ack
        start(1'b0, 10'h3FF, 16'h0000);
        check("rd_adr", wb_adr_o, 10'h3FF);
        check("rd_we", wb_we_o, 0);
        check("rd_rdy_early", drp_rdy, 0);
        wb_ack_i = 1'b1; wb_dat_i = 16'h1234;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
        check("rd_rdy", drp_rdy, 1);
        check("rd_do", drp_do, 16'h1234);
        tick();
        check("rd_rdy_pulse", drp_rdy, 0);
        check("rd_do_hold", drp_do, 16'h1234);

        // read with error
        start(1'b0, 10'h010, 16'h0000);
        wb_err_i = 1'b1; wb_dat_i = 16'h2222;
        tick();
        wb_err_i = 1'b0; wb_dat_i = 16'h0000;
        check("err_rdy", drp_rdy, 1);
        check("err_do", drp_do, 16'hFFFF);
        tick();

        // normal read to move drp_do away from ERR_DATA, then ack+err together
        start(1'b0, 10'h011, 16'h0000);
        wb_ack_i = 1'b1; wb_dat_i = 16'h5A5A;
        tick();
        wb_ack_i = 1'b0;
        check("pre_both_do", drp_do, 16'h5A5A);
        tick();
        start(1'b0, 10'h012, 16'h0000);
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 16'h0001;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 16'h0000;
        check("both_rdy", drp_rdy, 1);
        check("both_do", drp_do, 16'hFFFF);
        tick();

        // overrun: second drp_en while in BUS is ignored
        start(1'b0, 10'h020, 16'h0000);
        drp_en = 1'b1; drp_we = 1'b1; drp_addr = 10'h111; drp_di = 16'h9999;
        tick();
        drp_en = 1'b0; drp_we = 1'b0; drp_addr = '0; drp_di = '0;
        check("ovr_pulse", overrun, 1);
        check("ovr_adr", wb_adr_o, 10'h020);
        check("ovr_we", wb_we_o, 0);
        check("ovr_cyc", wb_cyc_o, 1);
        tick();
        check("ovr_pulse_end", overrun, 0);
        wb_ack_i = 1'b1; wb_dat_i = 16'h7777;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
        check("ovr_rdy", drp_rdy, 1);
        check("ovr_do", drp_do, 16'h7777);
        tick();

        // back-to-back: drp_en coincident with drp_rdy
        start(1'b0, 10'h030, 16'h0000);
        wb_ack_i = 1'b1; wb_dat_i = 16'h0A0A;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
        check("b2b_rdy", drp_rdy, 1);
        start(1'b1, 10'h031, 16'hCAFE);
        check("b2b_cyc", wb_cyc_o, 1);
        check("b2b_adr", wb_adr_o, 10'h031);
        check("b2b_dat", wb_dat_o, 16'hCAFE);
        check("b2b_we", wb_we_o, 1);
        check("b2b_ovr", overrun, 0);
        check("b2b_rdy_low", drp_rdy, 0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("b2b_wr_rdy", drp_rdy, 1);
        check("b2b_wr_do", drp_do, 16'h0A0A);
        tick();

        // ack in IDLE is ignored
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("idle_ack_rdy", drp_rdy, 0);
        check("idle_ack_cyc", wb_cyc_o, 0);

        // reset during BUS with an unresponsive slave
        start(1'b0, 10'h040, 16'h0000);
        check("rstbus_cyc", wb_cyc_o, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstbus_cyc_drop", wb_cyc_o, 0);
        check("rstbus_stb_drop", wb_stb_o, 0);
        check("rstbus_rdy", drp_rdy, 0);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (drp_rdy) hits++;
        end
        check("rstbus_no_rdy", hits, 0);
        start(1'b0, 10'h041, 16'h0000);
        wb_ack_i = 1'b1; wb_dat_i = 16'h4141;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
        check("post_rst_rdy", drp_rdy, 1);
        check("post_rst_do", drp_do, 16'h4141);
        tick();

`ifdef DRP_WB_TIMEOUT_EN
        // unresponsive slave: expiry after 16 bus cycles
        start(1'b0, 10'h050, 16'h0000);
        for (int i = 0; i < 15; i++) tick();
        check("to_cyc_before", wb_cyc_o, 1);
        check("to_rdy_before", drp_rdy, 0);
        tick();
        check("to_cyc_drop", wb_cyc_o, 0);
        check("to_rdy", drp_rdy, 1);
        check("to_pulse", timeout, 1);
        check("to_do", drp_do, 16'hFFFF);
        tick();
        check("to_pulse_end", timeout, 0);

        // ack on the 16th bus cycle wins over expiry
        start(1'b0, 10'h051, 16'h0000);
        for (int i = 0; i < 15; i++) tick();
        wb_ack_i = 1'b1; wb_dat_i = 16'h1616;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
        check("to_ack_rdy", drp_rdy, 1);
        check("to_ack_no_to", timeout, 0);
        check("to_ack_do", drp_do, 16'h1616);
        tick();
`else
        // without the timeout feature the bus phase waits indefinitely
        start(1'b0, 10'h050, 16'h0000);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (drp_rdy || timeout || !wb_cyc_o) hits++;
        end
        check("nto_wait", hits, 0);
        wb_ack_i = 1'b1; wb_dat_i = 16'h1616;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
        check("nto_rdy", drp_rdy, 1);
        check("nto_do", drp_do, 16'h1616);
        check("nto_to", timeout, 0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
